// File: rtl/audio_pwm_out.sv
// audio_pwm_out: multi-channel 1-bit audio output stage.
// Samples arrive through a small valid/ready FIFO and are popped once per
// sample period into the per-channel current-sample registers. Each channel
// is then modulated as PWM against a shared carrier counter, or as a
// first-order sigma-delta stream. An empty FIFO at a sample tick raises a
// sticky underrun flag.
module audio_pwm_out #(
   parameter int N_CHANNELS = 2,
   parameter int W_SAMPLE   = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int W_DIV      = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              cfg_en,
   input  logic                              cfg_mode,
   input  logic [W_DIV-1:0]                  cfg_div,
   input  logic [N_CHANNELS*W_SAMPLE-1:0]    sample_wdata,
   input  logic                              sample_vld,
   output logic                              sample_rdy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              underrun,
   input  logic                              underrun_clr,
   output logic [N_CHANNELS-1:0]             audio
);

   localparam int W_PTR  = $clog2(FIFO_DEPTH);
   localparam int W_LVL  = $clog2(FIFO_DEPTH + 1);
   localparam int W_DATA = N_CHANNELS * W_SAMPLE;

   localparam logic [W_LVL-1:0]    LVL_FULL = W_LVL'(FIFO_DEPTH);
   localparam logic [W_SAMPLE-1:0] CTR_MAX  = {W_SAMPLE{1'b1}};

   // FIFO storage and bookkeeping
   logic [W_DATA-1:0]   mem_r [FIFO_DEPTH];
   logic [W_PTR-1:0]    wr_ptr_r;
   logic [W_PTR-1:0]    rd_ptr_r;
   logic [W_LVL-1:0]    level_r;
   logic                rdy_r;

   // Sample-rate timing
   logic [W_SAMPLE-1:0] ctr_r;
   logic [W_DIV-1:0]    dctr_r;

   // Per-channel modulator state
   logic [W_SAMPLE-1:0] cur_r [N_CHANNELS];
   logic [W_SAMPLE:0]   acc_r [N_CHANNELS];
   logic [N_CHANNELS-1:0] audio_r;
   logic                underrun_r;

   // Combinational controls
   logic                empty_s;
   logic                push_s;
   logic                wrap_s;
   logic                tick_s;
   logic                pop_s;
   logic                set_underrun_s;
   logic [W_LVL-1:0]    level_nxt_s;
   logic [W_SAMPLE:0]   acc_nxt_s [N_CHANNELS];
   logic [N_CHANNELS-1:0] audio_nxt_s;

   // Push/pop/tick decisions, next FIFO level and next modulator values.
   always_comb begin
      empty_s        = (level_r == '0);
      push_s         = sample_vld && rdy_r;
      wrap_s         = cfg_en && (ctr_r == CTR_MAX);
      tick_s         = wrap_s && (dctr_r >= cfg_div);
      // No fall-through: a tick only sees entries already stored.
      pop_s          = tick_s && !empty_s;
      set_underrun_s = tick_s && empty_s;
      level_nxt_s    = level_r;
      audio_nxt_s    = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         acc_nxt_s[i] = '0;
      end

      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + W_LVL'(1);
         2'b01:   level_nxt_s = level_r - W_LVL'(1);
         default: level_nxt_s = level_r;
      endcase

      for (int i = 0; i < N_CHANNELS; i++) begin
         acc_nxt_s[i] = {1'b0, acc_r[i][W_SAMPLE-1:0]} + {1'b0, cur_r[i]};
         if (cfg_mode) begin
            audio_nxt_s[i] = acc_nxt_s[i][W_SAMPLE];
         end else begin
            audio_nxt_s[i] = (ctr_r < cur_r[i]);
         end
      end
   end

   // FIFO storage, pointers, occupancy and ready flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem_r[k] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
         rdy_r    <= 1'b1;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= sample_wdata;
            wr_ptr_r        <= wr_ptr_r + W_PTR'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + W_PTR'(1);
         end
         level_r <= level_nxt_s;
         rdy_r   <= (level_nxt_s != LVL_FULL);
      end
   end

   // Carrier counter and sample-rate divider; both idle at zero while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr_r  <= '0;
         dctr_r <= '0;
      end else if (!cfg_en) begin
         ctr_r  <= '0;
         dctr_r <= '0;
      end else begin
         ctr_r <= ctr_r + W_SAMPLE'(1);
         if (wrap_s) begin
            // >= so that lowering cfg_div mid-count ticks at the next wrap.
            if (dctr_r >= cfg_div) begin
               dctr_r <= '0;
            end else begin
               dctr_r <= dctr_r + W_DIV'(1);
            end
         end
      end
   end

   // Current samples: load the FIFO head on a tick, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CHANNELS; i++) begin
            cur_r[i] <= '0;
         end
      end else if (pop_s) begin
         for (int i = 0; i < N_CHANNELS; i++) begin
            cur_r[i] <= mem_r[rd_ptr_r][i*W_SAMPLE +: W_SAMPLE];
         end
      end
   end

   // Sigma-delta accumulators and the registered modulator outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CHANNELS; i++) begin
            acc_r[i] <= '0;
         end
         audio_r <= '0;
      end else if (!cfg_en) begin
         for (int i = 0; i < N_CHANNELS; i++) begin
            acc_r[i] <= '0;
         end
         audio_r <= '0;
      end else begin
         // Accumulators run in both modes so a mode switch needs no restart.
         for (int i = 0; i < N_CHANNELS; i++) begin
            acc_r[i] <= acc_nxt_s[i];
         end
         audio_r <= audio_nxt_s;
      end
   end

   // Sticky underrun flag; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_r <= 1'b0;
      end else if (set_underrun_s) begin
         underrun_r <= 1'b1;
      end else if (underrun_clr) begin
         underrun_r <= 1'b0;
      end
   end

   assign sample_rdy = rdy_r;
   assign fifo_level = level_r;
   assign underrun   = underrun_r;
   assign audio      = audio_r;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed testbench for audio_pwm_out with default parameters
// (2 channels, 8-bit samples, 4-entry FIFO, 8-bit divider).
// cyc counts rising edges since the modulators were last enabled; a value
// observed at cyc = c reflects the state after edge number c-1.
module tb_audio_pwm_out;

   logic        clk;
   logic        rst_n;
   logic        cfg_en;
   logic        cfg_mode;
   logic [7:0]  cfg_div;
   logic [15:0] sample_wdata;
   logic        sample_vld;
   logic        sample_rdy;
   logic [2:0]  fifo_level;
   logic        underrun;
   logic        underrun_clr;
   logic [1:0]  audio;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int c0, c1, t0;

   audio_pwm_out #(
      .N_CHANNELS (2),
      .W_SAMPLE   (8),
      .FIFO_DEPTH (4),
      .W_DIV      (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_en       (cfg_en),
      .cfg_mode     (cfg_mode),
      .cfg_div      (cfg_div),
      .sample_wdata (sample_wdata),
      .sample_vld   (sample_vld),
      .sample_rdy   (sample_rdy),
      .fifo_level   (fifo_level),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .audio        (audio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step(1);
   endtask

   task automatic enable();
      cfg_en = 1'b1;
      cyc    = 0;
   endtask

   task automatic push(input logic [15:0] d);
      sample_wdata = d;
      sample_vld   = 1'b1;
      step(1);
      sample_vld   = 1'b0;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      cfg_en       = 1'b0;
      sample_vld   = 1'b0;
      underrun_clr = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   // Count high samples per channel and channel-0 transitions over n cycles.
   task automatic measure(input int n, output int h0, output int h1, output int tr0);
      logic prev;
      h0 = 0; h1 = 0; tr0 = 0; prev = 1'b0;
      for (int k = 0; k < n; k++) begin
         step(1);
         if (audio[0]) h0++;
         if (audio[1]) h1++;
         if (k > 0 && audio[0] != prev) tr0++;
         prev = audio[0];
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      cfg_en       = 1'b0;
      cfg_mode     = 1'b0;
      cfg_div      = 8'd0;
      sample_wdata = 16'h0000;
      sample_vld   = 1'b0;
      underrun_clr = 1'b0;

      // Reset values
      step(2);
      check_eq("rst_audio", audio, 32'd0);
      check_eq("rst_rdy", sample_rdy, 32'd1);
      check_eq("rst_level", fifo_level, 32'd0);
      check_eq("rst_underrun", underrun, 32'd0);
      rst_n = 1'b1;
      step(1);

      // 1. PWM duty: ch0 = 0x40, ch1 = 0xC0, cfg_div = 0
      push(16'hC040);
      check_eq("pwm_level_push", fifo_level, 32'd1);
      enable();
      run_to(255);
      check_eq("pwm_level_pretick", fifo_level, 32'd1);
      step(1);
      check_eq("pwm_level_popped", fifo_level, 32'd0);
      check_eq("pwm_audio_pretick", audio, 32'd0);
      check_eq("pwm_underrun_pre", underrun, 32'd0);
      measure(256, c0, c1, t0);
      check_eq("pwm_ch0_high", c0, 32'd64);
      check_eq("pwm_ch1_high", c1, 32'd192);
      check_eq("pwm_underrun_2nd_tick", underrun, 32'd1);

      // 2. SDM: ch0 = 0x80 then 0x40, ch1 = 0x00
      do_reset();
      cfg_mode = 1'b1;
      push(16'h0080);
      push(16'h0040);
      enable();
      run_to(300);
      measure(16, c0, c1, t0);
      check_eq("sdm_half_high", c0, 32'd8);
      check_eq("sdm_half_toggles", t0, 32'd15);
      check_eq("sdm_zero_ch1", c1, 32'd0);
      run_to(600);
      measure(16, c0, c1, t0);
      check_eq("sdm_quarter_high", c0, 32'd4);
      check_eq("sdm_quarter_ch1", c1, 32'd0);
      check_eq("sdm_level", fifo_level, 32'd0);

      // 3. FIFO fill while disabled, then one pop per 512 clocks
      do_reset();
      cfg_mode = 1'b0;
      cfg_div  = 8'd1;
      for (int i = 0; i < 5; i++) begin
         sample_wdata = {8'(8 * (i + 1)), 8'(16 * (i + 1))};
         sample_vld   = 1'b1;
         step(1);
         if (i == 2) check_eq("fifo_rdy_at3", sample_rdy, 32'd1);
         if (i == 3) check_eq("fifo_rdy_full", sample_rdy, 32'd0);
      end
      sample_vld = 1'b0;
      check_eq("fifo_level_full", fifo_level, 32'd4);
      enable();
      run_to(511);
      check_eq("fifo_level_before_tick", fifo_level, 32'd4);
      step(1);
      check_eq("fifo_level_3", fifo_level, 32'd3);
      run_to(1024);
      check_eq("fifo_level_2", fifo_level, 32'd2);
      run_to(1536);
      check_eq("fifo_level_1", fifo_level, 32'd1);
      run_to(2048);
      check_eq("fifo_level_0", fifo_level, 32'd0);
      check_eq("fifo_underrun_none", underrun, 32'd0);
      measure(256, c0, c1, t0);
      check_eq("fifo_4th_ch0", c0, 32'd64);
      check_eq("fifo_4th_ch1", c1, 32'd32);

      // 4. Underrun at the next tick, cur held, clear loses to set
      run_to(2559);
      check_eq("udr_before", underrun, 32'd0);
      step(1);
      check_eq("udr_set", underrun, 32'd1);
      measure(256, c0, c1, t0);
      check_eq("udr_cur_held_ch0", c0, 32'd64);
      check_eq("udr_cur_held_ch1", c1, 32'd32);
      run_to(3071);
      underrun_clr = 1'b1;
      step(1);
      underrun_clr = 1'b0;
      check_eq("udr_set_beats_clr", underrun, 32'd1);
      underrun_clr = 1'b1;
      step(1);
      underrun_clr = 1'b0;
      check_eq("udr_cleared", underrun, 32'd0);

      // 5. Push on tick cycles: full FIFO refuses, two-entry FIFO keeps level
      do_reset();
      cfg_div = 8'd0;
      for (int i = 0; i < 4; i++) push(16'hE0E0);
      check_eq("edge_full_rdy", sample_rdy, 32'd0);
      enable();
      run_to(255);
      check_eq("edge_level_pre", fifo_level, 32'd4);
      sample_wdata = 16'hE0E0;
      sample_vld   = 1'b1;
      step(1);
      sample_vld   = 1'b0;
      check_eq("edge_full_tick_level", fifo_level, 32'd3);
      check_eq("edge_rdy_after_pop", sample_rdy, 32'd1);
      run_to(512);
      check_eq("edge_level_2", fifo_level, 32'd2);
      run_to(767);
      sample_wdata = 16'hE0E0;
      sample_vld   = 1'b1;
      step(1);
      sample_vld   = 1'b0;
      check_eq("edge_pushpop_level", fifo_level, 32'd2);

      // 6. Disable mid-period, resume with held cur, then async reset
      run_to(800);
      check_eq("ctl_audio_running", audio, 32'd3);
      cfg_en = 1'b0;
      step(1);
      check_eq("ctl_audio_off", audio, 32'd0);
      check_eq("ctl_level_kept", fifo_level, 32'd2);
      step(10);
      check_eq("ctl_level_kept_idle", fifo_level, 32'd2);
      enable();
      measure(256, c0, c1, t0);
      check_eq("ctl_cur_kept_ch0", c0, 32'd224);
      check_eq("ctl_cur_kept_ch1", c1, 32'd224);
      check_eq("ctl_level_after_tick", fifo_level, 32'd1);
      run_to(300);
      check_eq("ctl_audio_pre_rst", audio, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_audio", audio, 32'd0);
      check_eq("arst_level", fifo_level, 32'd0);
      check_eq("arst_rdy", sample_rdy, 32'd1);
      check_eq("arst_underrun", underrun, 32'd0);
      cfg_en = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
